// File: rtl/nd_2to1.sv
// nd_2to1: merges two four-phase req/ack inputs through per-input FIFOs onto one output, round-robin between heads.
// Latency rcv req -> snd req is 2 edges; a full FIFO withholds its input ack, and a busy output stalls both FIFOs.
`ifndef NS_MESSAGE_FIFO_SIZE
`define NS_MESSAGE_FIFO_SIZE 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif

module nd_2to1 #(
   parameter int FSZ = `NS_MESSAGE_FIFO_SIZE,
   parameter int ASZ = `NS_ADDRESS_SIZE,
   parameter int DSZ = `NS_DATA_SIZE
) (
   input  logic           i_clk,
   input  logic           reset,
   output logic           ready,
   input  logic [ASZ-1:0] rcv0_dst,
   input  logic [DSZ-1:0] rcv0_dat,
   input  logic           rcv0_req,
   output logic           rcv0_ack,
   input  logic [ASZ-1:0] rcv1_dst,
   input  logic [DSZ-1:0] rcv1_dat,
   input  logic           rcv1_req,
   output logic           rcv1_ack,
   output logic [ASZ-1:0] snd0_dst,
   output logic [DSZ-1:0] snd0_dat,
   output logic           snd0_req,
   input  logic           snd0_ack
);
   localparam int AW = $clog2(FSZ);
   localparam int CW = AW + 1;
   localparam int MW = ASZ + DSZ;
   localparam logic [CW-1:0] FULL_CNT = CW'(FSZ);

   logic          ready_q, ready_d;
   logic          ack0_q, ack0_d, ack1_q, ack1_d;
   logic          sreq_q, sreq_d;
   logic [MW-1:0] smsg_q, smsg_d;
   logic          rr_q, rr_d;
   logic [AW-1:0] head0_q, head0_d, tail0_q, tail0_d;
   logic [AW-1:0] head1_q, head1_d, tail1_q, tail1_d;
   logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic [MW-1:0] mem0 [FSZ];
   logic [MW-1:0] mem1 [FSZ];
   logic          ne0, ne1, push0, push1, pop0, pop1, load, gnt;

   always_comb begin
      ne0   = (cnt0_q != '0);
      ne1   = (cnt1_q != '0);
      // Full is judged on the registered count only: a same-edge pop never frees a slot for a push.
      push0 = ready_q && rcv0_req && !ack0_q && (cnt0_q != FULL_CNT);
      push1 = ready_q && rcv1_req && !ack1_q && (cnt1_q != FULL_CNT);
      load  = ready_q && !sreq_q && !snd0_ack && (ne0 || ne1);
      gnt   = (ne0 && ne1) ? rr_q : !ne0;
      pop0  = load && !gnt;
      pop1  = load && gnt;

      ready_d = 1'b1;
      ack0_d  = ack0_q;
      if (push0) ack0_d = 1'b1;
      else if (ready_q && !rcv0_req && ack0_q) ack0_d = 1'b0;
      ack1_d  = ack1_q;
      if (push1) ack1_d = 1'b1;
      else if (ready_q && !rcv1_req && ack1_q) ack1_d = 1'b0;

      sreq_d = sreq_q;
      smsg_d = smsg_q;
      rr_d   = rr_q;
      if (load) begin
         sreq_d = 1'b1;
         smsg_d = gnt ? mem1[head1_q] : mem0[head0_q];
         rr_d   = !gnt;
      end else if (ready_q && sreq_q && snd0_ack) begin
         sreq_d = 1'b0;
      end

      tail0_d = push0 ? tail0_q + AW'(1) : tail0_q;
      tail1_d = push1 ? tail1_q + AW'(1) : tail1_q;
      head0_d = pop0 ? head0_q + AW'(1) : head0_q;
      head1_d = pop1 ? head1_q + AW'(1) : head1_q;
      cnt0_d  = cnt0_q + CW'(push0) - CW'(pop0);
      cnt1_d  = cnt1_q + CW'(push1) - CW'(pop1);
   end

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         ready_q <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         sreq_q  <= 1'b0;
         smsg_q  <= '0;
         rr_q    <= 1'b0;
         head0_q <= '0;
         tail0_q <= '0;
         head1_q <= '0;
         tail1_q <= '0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         ready_q <= ready_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         sreq_q  <= sreq_d;
         smsg_q  <= smsg_d;
         rr_q    <= rr_d;
         head0_q <= head0_d;
         tail0_q <= tail0_d;
         head1_q <= head1_d;
         tail1_q <= tail1_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   // Storage needs no reset: entries are only read once the count says they were written.
   always_ff @(posedge i_clk) begin
      if (push0) mem0[tail0_q] <= {rcv0_dst, rcv0_dat};
      if (push1) mem1[tail1_q] <= {rcv1_dst, rcv1_dat};
   end

   assign ready    = ready_q;
   assign rcv0_ack = ack0_q;
   assign rcv1_ack = ack1_q;
   assign snd0_req = sreq_q;
   assign snd0_dst = smsg_q[MW-1:DSZ];
   assign snd0_dat = smsg_q[DSZ-1:0];

endmodule

// File: tb/tb_nd_2to1.sv
// Bench for nd_2to1: directed reset/latency/fairness/full/reset-recovery steps, then random traffic
// checked against per-input ordered queues.
module tb_nd_2to1;
   localparam int FSZ = 4;
   localparam int ASZ = 8;
   localparam int DSZ = 8;

   logic           i_clk = 1'b0;
   logic           reset;
   logic           ready;
   logic [ASZ-1:0] rcv0_dst, rcv1_dst, snd0_dst;
   logic [DSZ-1:0] rcv0_dat, rcv1_dat, snd0_dat;
   logic           rcv0_req, rcv0_ack, rcv1_req, rcv1_ack, snd0_req, snd0_ack;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] q0[$];
   logic [15:0] q1[$];

   always #5 i_clk = ~i_clk;

   nd_2to1 #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ)) dut (
      .i_clk(i_clk), .reset(reset), .ready(ready),
      .rcv0_dst(rcv0_dst), .rcv0_dat(rcv0_dat), .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack),
      .rcv1_dst(rcv1_dst), .rcv1_dat(rcv1_dat), .rcv1_req(rcv1_req), .rcv1_ack(rcv1_ack),
      .snd0_dst(snd0_dst), .snd0_dat(snd0_dat), .snd0_req(snd0_req), .snd0_ack(snd0_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic get_ack(input int k);
      return (k == 0) ? rcv0_ack : rcv1_ack;
   endfunction

   task automatic drive(input int k, input logic [7:0] d, input logic [7:0] v, input logic r);
      if (k == 0) begin
         rcv0_dst = d; rcv0_dat = v; rcv0_req = r;
      end else begin
         rcv1_dst = d; rcv1_dat = v; rcv1_req = r;
      end
   endtask

   task automatic send(input int k, input logic [7:0] d, input logic [7:0] v, input int gap);
      int w;
      repeat (gap) tick();
      drive(k, d, v, 1'b1);
      for (w = 0; w < 60 && get_ack(k) !== 1'b1; w++) tick();
      chk("send_ack_rise", get_ack(k), 1);
      drive(k, d, v, 1'b0);
      for (w = 0; w < 10 && get_ack(k) !== 1'b0; w++) tick();
      chk("send_ack_fall", get_ack(k), 0);
   endtask

   task automatic recv(output logic [15:0] msg, input int dly);
      int w;
      for (w = 0; w < 200 && snd0_req !== 1'b1; w++) tick();
      chk("recv_req_rise", snd0_req, 1);
      msg = {snd0_dst, snd0_dat};
      repeat (dly) tick();
      snd0_ack = 1'b1;
      for (w = 0; w < 10 && snd0_req !== 1'b0; w++) tick();
      chk("recv_req_fall", snd0_req, 0);
      snd0_ack = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      rcv0_req = 1'b0; rcv1_req = 1'b0; snd0_ack = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      logic [15:0] m;
      logic [7:0]  fair_exp [8];
      int          n_acks;
      int          w;
      logic        acked;
      logic        stale;

      // reset held with random inputs, checked before any clock edge
      reset = 1'b0;
      rcv0_dst = 8'($urandom); rcv0_dat = 8'($urandom); rcv0_req = 1'($urandom);
      rcv1_dst = 8'($urandom); rcv1_dat = 8'($urandom); rcv1_req = 1'($urandom);
      snd0_ack = 1'($urandom);
      #2;
      chk("rst_ready", ready, 0);
      chk("rst_rcv0_ack", rcv0_ack, 0);
      chk("rst_rcv1_ack", rcv1_ack, 0);
      chk("rst_snd0_req", snd0_req, 0);
      chk("rst_snd0_dst", snd0_dst, 0);
      chk("rst_snd0_dat", snd0_dat, 0);
      repeat (3) begin
         tick();
         rcv0_req = 1'($urandom); rcv1_req = 1'($urandom); snd0_ack = 1'($urandom);
      end
      chk("rst_hold_req", snd0_req, 0);
      chk("rst_hold_ack0", rcv0_ack, 0);

      // release with a pending request on input 0: the init edge must not ack it
      rcv1_req = 1'b0; snd0_ack = 1'b0;
      drive(0, 8'd5, 8'hA5, 1'b1);
      #2 reset = 1'b1;
      tick();
      chk("init_ready", ready, 1);
      chk("init_no_ack", rcv0_ack, 0);
      tick();
      chk("path_ack_E", rcv0_ack, 1);
      chk("path_req_E", snd0_req, 0);
      tick();
      chk("path_req_E1", snd0_req, 1);
      chk("path_dst", snd0_dst, 5);
      chk("path_dat", snd0_dat, 8'hA5);
      rcv0_req = 1'b0;
      tick();
      chk("path_ack_drop", rcv0_ack, 0);
      snd0_ack = 1'b1;
      tick();
      chk("path_req_drop", snd0_req, 0);
      snd0_ack = 1'b0;
      tick();
      chk("ready_stays", ready, 1);

      // fairness: both inputs queue 4 messages while the output is held, then drain
      do_reset();
      fork
         for (int i = 0; i < 4; i++) send(0, 8'd0, 8'(i), 0);
         for (int i = 0; i < 4; i++) send(1, 8'd1, 8'(8'h10 + i), 0);
      join
      fair_exp = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13};
      for (int i = 0; i < 8; i++) begin
         recv(m, 0);
         chk("fair_order", m[7:0], fair_exp[i]);
      end

      // simultaneous requests on empty FIFOs; input 0 is favoured after the last grant went to 1
      drive(0, 8'd0, 8'h31, 1'b1);
      drive(1, 8'd1, 8'h41, 1'b1);
      tick();
      chk("simul_ack0", rcv0_ack, 1);
      chk("simul_ack1", rcv1_ack, 1);
      rcv0_req = 1'b0; rcv1_req = 1'b0;
      tick();
      recv(m, 0);
      chk("simul_first", m, 16'h0031);
      recv(m, 0);
      chk("simul_second", m, 16'h0141);

      // full: six pushes on input 1 with the output held; five fit (FIFO plus output register)
      n_acks = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 8'd1, 8'(8'h20 + i), 1'b1);
         acked = 1'b0;
         for (w = 0; w < 8 && !acked; w++) begin
            tick();
            acked = (rcv1_ack === 1'b1);
         end
         if (acked) begin
            n_acks++;
            rcv1_req = 1'b0;
            for (w = 0; w < 8 && rcv1_ack !== 1'b0; w++) tick();
         end
      end
      chk("full_ack_count", n_acks, 5);
      chk("full_waiting", rcv1_ack, 0);
      recv(m, 0);
      chk("full_first_out", m, 16'h0120);
      for (w = 0; w < 8 && rcv1_ack !== 1'b1; w++) tick();
      chk("full_sixth_ack", rcv1_ack, 1);
      rcv1_req = 1'b0;
      tick();
      for (int i = 1; i < 6; i++) begin
         recv(m, 0);
         chk("full_order", m, 16'h0120 + 16'(i));
      end

      // reset mid-operation with the output loaded and two entries in each FIFO
      fork
         for (int i = 0; i < 3; i++) send(0, 8'd0, 8'(8'h50 + i), 0);
         for (int i = 0; i < 2; i++) send(1, 8'd1, 8'(8'h60 + i), 0);
      join
      tick();
      chk("mid_req_busy", snd0_req, 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_ready", ready, 0);
      chk("mid_req", snd0_req, 0);
      chk("mid_dst", snd0_dst, 0);
      chk("mid_dat", snd0_dat, 0);
      chk("mid_ack0", rcv0_ack, 0);
      chk("mid_ack1", rcv1_ack, 0);
      tick();
      reset = 1'b1;
      tick();
      chk("mid_reinit", ready, 1);
      stale = 1'b0;
      repeat (20) begin
         snd0_ack = 1'($urandom);
         tick();
         if (snd0_req !== 1'b0) stale = 1'b1;
      end
      snd0_ack = 1'b0;
      chk("mid_no_stale", stale, 0);

      // random traffic; every output must be the oldest outstanding message of its input
      fork
         for (int i = 0; i < 20; i++) begin
            logic [7:0] v0;
            v0 = 8'($urandom);
            q0.push_back({8'(i), v0});
            send(0, 8'(i), v0, $urandom_range(0, 3));
         end
         for (int i = 0; i < 20; i++) begin
            logic [7:0] v1;
            v1 = 8'($urandom);
            q1.push_back({8'h80 | 8'(i), v1});
            send(1, 8'h80 | 8'(i), v1, $urandom_range(0, 3));
         end
         for (int i = 0; i < 40; i++) begin
            logic [15:0] rm, re;
            recv(rm, $urandom_range(0, 2));
            re = 'x;
            if (rm[15] && q1.size() > 0) re = q1.pop_front();
            else if (!rm[15] && q0.size() > 0) re = q0.pop_front();
            chk("rand_msg", rm, re);
         end
      join
      chk("rand_q0_drained", q0.size(), 0);
      chk("rand_q1_drained", q1.size(), 0);
      tick();
      chk("rand_idle", snd0_req, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
